// File: rtl/fma_vec_if.sv
// fma_vec_if: configuration, operand and result signals of the vector
// multiply-accumulate block, bundled so streamers and writers plug in as one port.
//   master : drives param_*, data_ena, dataa_in, datab_in, bias_dat;
//            observes bias_req, data_act, data_out, busy, err_ovf
//   slave  : the fma_vec side (directions mirrored)
interface fma_vec_if #(
  parameter int LDW = 16,
  parameter int LPW = 4,
  parameter int WDW = 16
);
  logic                 param_ena;
  logic [WDW-1:0]       param_ilength;
  logic                 param_relu;
  logic                 data_ena;
  logic [LDW*LPW-1:0]   dataa_in;
  logic [LDW*LPW-1:0]   datab_in;
  logic                 bias_req;
  logic [LDW-1:0]       bias_dat;
  logic                 data_act;
  logic [LDW-1:0]       data_out;
  logic                 busy;
  logic                 err_ovf;

  modport master (
    output param_ena, param_ilength, param_relu, data_ena, dataa_in, datab_in, bias_dat,
    input  bias_req, data_act, data_out, busy, err_ovf
  );

  modport slave (
    input  param_ena, param_ilength, param_relu, data_ena, dataa_in, datab_in, bias_dat,
    output bias_req, data_act, data_out, busy, err_ovf
  );
endinterface

// File: rtl/fma_vec.sv
// fma_vec: signed fixed-point vector multiply-accumulate.
// Each beat multiplies LPW lane pairs, reduces the products through a pipelined
// adder tree and accumulates over ilength beats; the final sum gets a per-output
// bias, is rounded half-up back to Q.FRAC, optionally ReLU-clamped and saturated.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : asynchronous active-low reset
//   ifc  : fma_vec_if.slave (config, beat operands, bias handshake, result, status)
module fma_vec #(
  parameter int LDW  = 16,
  parameter int LPW  = 4,
  parameter int FRAC = 8,
  parameter int WDW  = 16
) (
  input  logic     clk,
  input  logic     rst,
  fma_vec_if.slave ifc
);
  localparam int T   = $clog2(LPW);
  localparam int NP  = 1 << T;          // tree leaves, lanes beyond LPW are zero
  localparam int SW  = 2*LDW + T;       // tree node width
  localparam int ACW = 2*LDW + T + WDW; // accumulator width
  localparam int BW  = ACW + 2;         // biased/rounded width, headroom for bias and rounding
  localparam logic signed [BW-1:0] HALF = BW'(1) << (FRAC-1);

  // Input stage (zero-padded up to NP lanes)
  logic [NP*LDW-1:0]     a_q, b_q;
  logic                  vin_q;
  // Adder tree kept as a heap: leaves at [NP-1 .. 2NP-2], node i sums 2i+1 and 2i+2,
  // so every node registers once per cycle and the root lags the leaves by T stages.
  logic signed [SW-1:0]  node_q [2*NP-1];
  logic [T:0]            vt_q;
  // Accumulation / hold
  logic signed [ACW-1:0] acc_q, hold_q, acc_sum;
  logic [WDW-1:0]        cnt_q, ilen_q, ilen_eff;
  logic                  relu_q, last, hold_v_q;
  // Bias / output
  logic signed [BW-1:0]  bsum_q, rnd, shf, shf_r;
  logic                  bv_q;
  logic [BW-LDW:0]       hi;
  logic [LDW-1:0]        res_d, data_out_q;
  logic                  sat_d, data_act_q, err_q, busy_d, cfg_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      vin_q <= 1'b0;
    end else begin
      vin_q <= ifc.data_ena;
      if (ifc.data_ena) begin
        a_q <= (NP*LDW)'(ifc.dataa_in);
        b_q <= (NP*LDW)'(ifc.datab_in);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2*NP-1; i++) node_q[i] <= '0;
      vt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NP; i++)
        node_q[NP-1+i] <= SW'($signed(a_q[i*LDW +: LDW])) * SW'($signed(b_q[i*LDW +: LDW]));
      for (int unsigned i = 0; i < NP-1; i++)
        node_q[i] <= node_q[2*i+1] + node_q[2*i+2];
      vt_q[0] <= vin_q;
      for (int unsigned l = 1; l <= T; l++) vt_q[l] <= vt_q[l-1];
    end
  end

  always_comb begin
    ilen_eff = (ilen_q == '0) ? WDW'(1) : ilen_q;
    last     = (cnt_q == ilen_eff - WDW'(1));
    acc_sum  = acc_q + ACW'(node_q[0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      hold_v_q <= 1'b0;
    end else begin
      hold_v_q <= vt_q[T] & last;
      if (vt_q[T]) begin
        if (last) begin
          hold_q <= acc_sum;
          acc_q  <= '0;
          cnt_q  <= '0;
        end else begin
          acc_q  <= acc_sum;
          cnt_q  <= cnt_q + WDW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bsum_q <= '0;
      bv_q   <= 1'b0;
    end else begin
      bv_q <= hold_v_q;
      if (hold_v_q)
        bsum_q <= BW'(hold_q) + (BW'($signed(ifc.bias_dat)) <<< FRAC);
    end
  end

  // Round half up, rescale, ReLU, then saturate: the result fits when every bit
  // from the output sign bit upward is identical.
  always_comb begin
    rnd   = bsum_q + HALF;
    shf   = rnd >>> FRAC;
    shf_r = (relu_q && shf[BW-1]) ? '0 : shf;
    hi    = shf_r[BW-1:LDW-1];
    sat_d = !((&hi) || !(|hi));
    if (sat_d) res_d = shf_r[BW-1] ? {1'b1, {(LDW-1){1'b0}}} : {1'b0, {(LDW-1){1'b1}}};
    else       res_d = shf_r[LDW-1:0];
  end

  always_comb begin
    busy_d = vin_q | (|vt_q) | hold_v_q | bv_q | (cnt_q != '0);
    cfg_we = ifc.param_ena & ~busy_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ilen_q     <= WDW'(1);
      relu_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      data_act_q <= 1'b0;
    end else begin
      data_act_q <= bv_q;
      if (bv_q) begin
        data_out_q <= res_d;
        if (sat_d) err_q <= 1'b1;
      end
      // bv_q implies busy, so a config load never coincides with a saturation update
      if (cfg_we) begin
        ilen_q <= ifc.param_ilength;
        relu_q <= ifc.param_relu;
        err_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    ifc.bias_req = hold_v_q;
    ifc.data_act = data_act_q;
    ifc.data_out = data_out_q;
    ifc.busy     = busy_d;
    ifc.err_ovf  = err_q;
  end
endmodule

// File: tb/tb_fma_vec.sv
// tb_fma_vec: directed self-checking bench for fma_vec at default parameters
// (Q8.8, four lanes). Each task drives one scenario and checks inline.
module tb_fma_vec;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fma_vec_if #(.LDW(16), .LPW(4), .WDW(16)) ifc ();

  fma_vec #(.LDW(16), .LPW(4), .FRAC(8), .WDW(16)) dut (
    .clk(clk),
    .rst(rst),
    .ifc(ifc.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [15:0] x);
    return {4{x}};
  endfunction

  // One beat; returns just after the sampling edge (E0)
  task automatic send(input logic [63:0] a, input logic [63:0] b);
    ifc.data_ena = 1'b1;
    ifc.dataa_in = a;
    ifc.datab_in = b;
    step();
    ifc.data_ena = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] il, input logic rl);
    ifc.param_ena     = 1'b1;
    ifc.param_ilength = il;
    ifc.param_relu    = rl;
    step();
    ifc.param_ena     = 1'b0;
  endtask

  // Edges counted after E0 until data_act; -1 means it never came
  task automatic wait_out(output logic [15:0] d, output int c_req, output int c_act);
    c_req = -1;
    c_act = -1;
    d     = 'x;
    for (int k = 1; k <= 30 && c_act < 0; k++) begin
      step();
      if (ifc.bias_req && c_req < 0) c_req = k;
      if (ifc.data_act) begin
        c_act = k;
        d     = ifc.data_out;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (ifc.data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out got=%h want=0000", ifc.data_out); end
    checks++; if (ifc.data_act !== 1'b0) begin errors++; $display("FAIL reset_data_act got=%b want=0", ifc.data_act); end
    checks++; if (ifc.bias_req !== 1'b0) begin errors++; $display("FAIL reset_bias_req got=%b want=0", ifc.bias_req); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", ifc.busy); end
    checks++; if (ifc.err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err_ovf got=%b want=0", ifc.err_ovf); end
  endtask

  task automatic test_basic();
    logic [15:0] d; int cr, ca;
    cfg(16'd1, 1'b0);
    ifc.bias_dat = 16'h0080;
    send(rep(16'h0100), rep(16'h0200));
    wait_out(d, cr, ca);
    checks++; if (cr !== 4) begin errors++; $display("FAIL basic_bias_req_lat got=%0d want=4", cr); end
    checks++; if (ca !== 6) begin errors++; $display("FAIL basic_act_lat got=%0d want=6", ca); end
    checks++; if (d !== 16'h0880) begin errors++; $display("FAIL basic_data got=%h want=0880", d); end
    step();
    checks++; if (ifc.data_act !== 1'b0) begin errors++; $display("FAIL basic_act_pulse got=%b want=0", ifc.data_act); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b want=0", ifc.busy); end
    ifc.bias_dat = 16'h0000;
  endtask

  task automatic test_back_to_back();
    int n; int t [2]; logic [15:0] v [2];
    n = 0; t[0] = -100; t[1] = -100; v[0] = 'x; v[1] = 'x;
    cfg(16'd3, 1'b0);
    for (int i = 0; i < 6; i++) send(rep(16'h0100), rep(16'h0200));
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ifc.data_act) begin
        if (n < 2) begin t[n] = k; v[n] = ifc.data_out; end
        n++;
      end
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_count got=%0d want=2", n); end
    checks++; if (v[0] !== 16'h1800) begin errors++; $display("FAIL b2b_out0 got=%h want=1800", v[0]); end
    checks++; if (v[1] !== 16'h1800) begin errors++; $display("FAIL b2b_out1 got=%h want=1800", v[1]); end
    checks++; if (t[0] !== 3) begin errors++; $display("FAIL b2b_first_time got=%0d want=3", t[0]); end
    checks++; if (t[1] - t[0] !== 3) begin errors++; $display("FAIL b2b_spacing got=%0d want=3", t[1] - t[0]); end
  endtask

  task automatic test_relu();
    logic [15:0] d; int cr, ca;
    cfg(16'd1, 1'b0);
    send(rep(16'hFF00), rep(16'h0200));
    wait_out(d, cr, ca);
    checks++; if (d !== 16'hF800) begin errors++; $display("FAIL relu_off got=%h want=F800", d); end
    cfg(16'd1, 1'b1);
    send(rep(16'hFF00), rep(16'h0200));
    wait_out(d, cr, ca);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL relu_on got=%h want=0000", d); end
    checks++; if (ifc.err_ovf !== 1'b0) begin errors++; $display("FAIL relu_err got=%b want=0", ifc.err_ovf); end
  endtask

  task automatic test_saturate();
    logic [15:0] d; int cr, ca;
    cfg(16'd1, 1'b0);
    send(rep(16'h7F00), rep(16'h7F00));
    wait_out(d, cr, ca);
    checks++; if (d !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%h want=7FFF", d); end
    checks++; if (ifc.err_ovf !== 1'b1) begin errors++; $display("FAIL sat_pos_err got=%b want=1", ifc.err_ovf); end
    send(rep(16'h8100), rep(16'h7F00));
    wait_out(d, cr, ca);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL sat_neg got=%h want=8000", d); end
    // param_ena while busy must not clear the sticky flag
    send(rep(16'h0000), rep(16'h0000));
    ifc.param_ena = 1'b1; ifc.param_ilength = 16'd1; ifc.param_relu = 1'b0;
    step();
    ifc.param_ena = 1'b0;
    checks++; if (ifc.err_ovf !== 1'b1) begin errors++; $display("FAIL sat_err_busy_hold got=%b want=1", ifc.err_ovf); end
    wait_out(d, cr, ca);
    checks++; if (d !== 16'h0000 || ca !== 5) begin errors++; $display("FAIL sat_zero_beat got=%h/%0d want=0000/5", d, ca); end
    cfg(16'd1, 1'b0);
    checks++; if (ifc.err_ovf !== 1'b0) begin errors++; $display("FAIL sat_err_clear got=%b want=0", ifc.err_ovf); end
  endtask

  task automatic test_rounding();
    logic [15:0] d; int cr, ca;
    cfg(16'd1, 1'b0);
    send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0080);
    wait_out(d, cr, ca);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL round_half_up got=%h want=0001", d); end
    send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_007F);
    wait_out(d, cr, ca);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL round_below_half got=%h want=0000", d); end
  endtask

  task automatic test_config();
    logic [15:0] d; int cr, ca;
    cfg(16'd0, 1'b0);
    send(rep(16'h0100), rep(16'h0200));
    wait_out(d, cr, ca);
    checks++; if (d !== 16'h0800 || ca !== 6) begin errors++; $display("FAIL ilen0 got=%h/%0d want=0800/6", d, ca); end
    // ilen=2; attempted change to ilen=1/relu=1 while busy is ignored
    cfg(16'd2, 1'b0);
    send(rep(16'hFF00), rep(16'h0200));
    ifc.param_ena = 1'b1; ifc.param_ilength = 16'd1; ifc.param_relu = 1'b1;
    step();
    ifc.param_ena = 1'b0;
    send(rep(16'hFF00), rep(16'h0200));
    wait_out(d, cr, ca);
    checks++; if (d !== 16'hF000 || ca !== 6) begin errors++; $display("FAIL busy_ignore got=%h/%0d want=F000/6", d, ca); end
    // Config and beat together while idle: new ilen=1 governs this beat
    ifc.param_ena = 1'b1; ifc.param_ilength = 16'd1; ifc.param_relu = 1'b0;
    send(rep(16'h0100), rep(16'h0200));
    ifc.param_ena = 1'b0;
    wait_out(d, cr, ca);
    checks++; if (d !== 16'h0800 || ca !== 6) begin errors++; $display("FAIL cfg_with_beat got=%h/%0d want=0800/6", d, ca); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; int cr, ca, pulses;
    cfg(16'd3, 1'b0);
    ifc.bias_dat = 16'h0080;
    send(rep(16'h0100), rep(16'h0200));
    send(rep(16'h0100), rep(16'h0200));
    rst = 1'b0;
    #1;
    checks++; if (ifc.data_out !== 16'h0000) begin errors++; $display("FAIL rstmid_data_out got=%h want=0000", ifc.data_out); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", ifc.busy); end
    step(); step();
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (ifc.data_act || ifc.bias_req) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_pulse got=%0d want=0", pulses); end
    send(rep(16'h0100), rep(16'h0200));
    wait_out(d, cr, ca);
    checks++; if (d !== 16'h0880 || ca !== 6) begin errors++; $display("FAIL rstmid_next got=%h/%0d want=0880/6", d, ca); end
  endtask

  initial begin
    ifc.param_ena = 1'b0; ifc.param_ilength = 16'd1; ifc.param_relu = 1'b0;
    ifc.data_ena = 1'b0; ifc.dataa_in = '0; ifc.datab_in = '0; ifc.bias_dat = '0;
    rst = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    test_reset();
    test_basic();
    test_back_to_back();
    test_relu();
    test_saturate();
    test_rounding();
    test_config();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
